// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the front-end blocks.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0]      OPCODE_JAL       = 7'b1101111;
    localparam logic [31:0]     INSN_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/jal_predecode.sv
// Combinational JAL detector: flags the JAL opcode and returns the sign-extended J-immediate.
module jal_predecode
    import riscv_pkg::*;
(
    input  logic [31:0]     instr,
    output logic            is_jal,
    output logic [XLEN-1:0] imm
);

    // rd is irrelevant to the predicted target
    logic [4:0] rd_unused;

    assign rd_unused = instr[11:7];
    assign is_jal    = (instr[6:0] == OPCODE_JAL);
    assign imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, addresses the synchronous ROM and hands words to decode.
// Define IFETCH_JAL_PREDICT_EN to follow JALs with zero bubbles.
module ifetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_pred_taken,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] redir_addr;
    logic [XLEN-1:0] fetch_addr;
    logic            fire;
    logic            issue;
    logic            pred_taken;
    logic [1:0]      redirect_lsb_unused;

    assign redirect_lsb_unused = redirect_pc[1:0];
    assign redir_addr          = {redirect_pc[XLEN-1:2], 2'b00};

    assign if_valid      = out_valid_q & ~redirect_valid;
    assign fire          = if_valid & if_ready;
    assign if_pc         = out_pc_q;
    assign if_instr      = imem_rdata;
    assign if_pred_taken = pred_taken;
    assign imem_addr     = fetch_addr;

`ifdef IFETCH_JAL_PREDICT_EN
    logic            is_jal;
    logic [XLEN-1:0] jal_imm;

    jal_predecode u_predecode (
        .instr  (imem_rdata),
        .is_jal (is_jal),
        .imm    (jal_imm)
    );

    assign pred_taken = if_valid & is_jal;
`else
    assign pred_taken = 1'b0;
`endif

    // Redirect, advance and stall all reduce to "pick an address, and optionally issue it".
    always_comb begin
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        fetch_addr  = out_pc_q;
        issue       = 1'b0;

        if (redirect_valid) begin
            fetch_addr = redir_addr;
            issue      = 1'b1;
        end else if (!out_valid_q || fire) begin
            fetch_addr = pc_q;
`ifdef IFETCH_JAL_PREDICT_EN
            if (pred_taken) begin
                fetch_addr = out_pc_q + jal_imm;
            end
`endif
            issue = 1'b1;
        end

        if (issue) begin
            out_pc_d    = fetch_addr;
            out_valid_d = 1'b1;
            pc_d        = fetch_addr + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_pc_q    <= RESET_PC;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: program-order fetch model plus directed literal checks.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] JAL_WORD = 32'h0200_006F;  // jal x0, +0x20

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pred_taken  (if_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // ROM contents: a JAL at 0x10, OP-IMM filler words everywhere else.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h10) return JAL_WORD;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        return {h[31:7], 7'h13};
    endfunction

    function automatic logic word_is_jal(input logic [31:0] w);
`ifdef IFETCH_JAL_PREDICT_EN
        return w[6:0] == 7'b1101111;
`else
        return (w != w);
`endif
    endfunction

    // J-type immediate: imm[20|10:1|11|19:12] in instr[31:12]
    function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] w);
        int signed off;
        off = 0;
        off += int'(w[30:21]) * 2;
        off += int'(w[20]) * 2048;
        off += int'(w[19:12]) * 4096;
        if (w[31]) off -= 1048576;
        return pc + 32'(off);
    endfunction

    function automatic logic [31:0] next_seq(input logic [31:0] pc);
        logic [31:0] w;
        w = rom_word(pc);
        if (word_is_jal(w)) return jal_target(pc, w);
        return pc + 32'd4;
    endfunction

    always @(posedge clk) imem_rdata <= rom_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the word decode should see now, and whether one is presentable.
    logic [31:0] m_pc    = RESET_PC;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = RESET_PC;
        end else if (redirect_valid) begin
            m_valid = 1'b1;
            m_pc    = {redirect_pc[31:2], 2'b00};
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else if (if_ready) begin
            m_pc = next_seq(m_pc);
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_addr;
        logic        exp_v;
        if (!rst) begin
            exp_v = m_valid & !redirect_valid;
            chk("valid", {31'd0, if_valid}, {31'd0, exp_v});
            if (redirect_valid)            exp_addr = {redirect_pc[31:2], 2'b00};
            else if (!m_valid || !if_ready) exp_addr = m_pc;
            else                            exp_addr = next_seq(m_pc);
            chk("imem_addr", imem_addr, exp_addr);
            if (exp_v) begin
                chk("if_pc", if_pc, m_pc);
                chk("if_instr", if_instr, rom_word(m_pc));
                chk("pred", {31'd0, if_pred_taken}, {31'd0, word_is_jal(rom_word(m_pc))});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string name, input logic [31:0] pc);
        chk({name, "_v"}, {31'd0, if_valid}, 32'd1);
        chk({name, "_pc"}, if_pc, pc);
    endtask

    logic [31:0] held;

    initial begin
        rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) tick;

        // reset release: one empty cycle, then 0, 4, 8 back to back
        rst = 1'b0; #1;
        chk("rel_valid", {31'd0, if_valid}, 32'd0);
        chk("rel_addr", imem_addr, 32'h0);
        tick; #1; chk_word("first", 32'h0);
        tick; #1; chk_word("seq4", 32'h4);
        tick; #1; chk_word("seq8", 32'h8);

        // three-cycle stall at 8
        if_ready = 1'b0; #1;
        chk("stall_addr", imem_addr, 32'h8);
        held = if_instr;
        repeat (2) begin
            tick; #1;
            chk_word("stall", 32'h8);
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_instr", if_instr, held);
        end
        if_ready = 1'b1;
        tick; #1; chk_word("release", 32'hC);
        tick; #1; chk_word("seq16", 32'h10);

        // redirect while stalled
        if_ready = 1'b0;
        tick; #1;
        redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        tick; redirect_valid = 1'b0; if_ready = 1'b1; #1;
        chk_word("tgt", 32'h100);
        tick; #1; chk_word("tgt4", 32'h104);

        // wrap through 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick; redirect_valid = 1'b0; #1;
        chk_word("wrap_top", 32'hFFFF_FFFC);
        tick; #1; chk_word("wrap_zero", 32'h0);

        // reset mid-stream at 0x40
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick; redirect_valid = 1'b0; #1;
        chk_word("at40", 32'h40);
        rst = 1'b1;
        tick; rst = 1'b0; #1;
        chk("rst_drop", {31'd0, if_valid}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        tick; #1; chk_word("restart", RESET_PC);

        // JAL at 0x10
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        tick; redirect_valid = 1'b0; #1;
        chk_word("j8", 32'h8);
        tick; #1; chk_word("jc", 32'hC);
        tick; #1; chk_word("jal", 32'h10);
`ifdef IFETCH_JAL_PREDICT_EN
        chk("jal_pred", {31'd0, if_pred_taken}, 32'd1);
        tick; #1; chk_word("jal_next", 32'h30);
`else
        chk("jal_pred", {31'd0, if_pred_taken}, 32'd0);
        tick; #1; chk_word("jal_next", 32'h14);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick;
            if_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'h8 + 32'($urandom_range(0, 7));
                2:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: redirect_pc = 32'($urandom_range(0, 255));
            endcase
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0; redirect_valid = 1'b0;
        repeat (3) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
